aes_rx_deframer: RTL and testbench

Platform-side receiver for the AES chip's byte-serial output port. It sits in the verification platform on the 50 MHz platform clock, opposite the chip's `chip_data[7:0]`/`sho` output pair, i.e. on the `aes_rx[8:0]` bus. It synchronizes the chip-clocked strobe, captures one byte per `sho` rising edge, and assembles 16 bytes into a 128-bit ciphertext block for the platform's compare/count logic. It detects stalled or truncated frames with an inter-byte timeout.

---
 rtl/aes_plat_pkg.sv | 13 +
 rtl/plat_sync2.sv | 24 ++
 rtl/aes_rx_deframer.sv | 136 +++++++++++++
 tb/tb_aes_rx_deframer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_plat_pkg.sv
// Shared constants and types for the AES verification platform byte-serial links.
package aes_plat_pkg;
    localparam int BYTE_W    = 8;
    localparam int BLK_W     = 128;
    localparam int BLK_BYTES = 16;
    // Strobe position on both the aes_tx and aes_rx buses.
    localparam int STB_BIT   = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_e;
endpackage

// File: rtl/plat_sync2.sv
// Two-flop synchronizer for signals crossing into the platform clock domain.
module plat_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;
endmodule

// File: rtl/aes_rx_deframer.sv
// Receives the AES chip's byte-serial output, assembles 16-byte ciphertext blocks
// and flags frames that stall between bytes.
module aes_rx_deframer
    import aes_plat_pkg::*;
#(
    parameter int CLK_FREQ       = 50_000_000,
    parameter int CHIP_CLK_FREQ  = 1_000_000,
    // Ratio taken first so the product stays inside 32 bits.
    parameter int TIMEOUT_CYCLES = 64 * (CLK_FREQ / CHIP_CLK_FREQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [8:0]       aes_rx,
    input  logic             abort,
    output logic             blk_valid,
    output logic [BLK_W-1:0] blk_data,
    output logic             frame_err,
    output logic             busy,
    output logic [4:0]       byte_cnt
);
    localparam int TMR_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TMR_W   = (TMR_RAW > 12) ? TMR_RAW : 12;
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]       LAST_IDX = 5'(BLK_BYTES - 1);

    logic              sho_s2;
    logic              s3_q;
    logic [BYTE_W-1:0] data_s2;
    logic              sho_edge;

    // Data rides an identical pipeline so it lines up with the strobe edge.
    plat_sync2 #(.WIDTH(1)) u_sync_sho (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (aes_rx[STB_BIT]),
        .q     (sho_s2)
    );

    plat_sync2 #(.WIDTH(BYTE_W)) u_sync_data (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (aes_rx[BYTE_W-1:0]),
        .q     (data_s2)
    );

    assign sho_edge = sho_s2 & ~s3_q;

    state_e             state_q, state_d;
    logic [BLK_W-1:0]   shreg_q, shreg_d;
    logic [BLK_W-1:0]   blk_data_q, blk_data_d;
    logic [4:0]         byte_cnt_q, byte_cnt_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               blk_valid_q, blk_valid_d;
    logic               frame_err_q, frame_err_d;
    logic               busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        blk_data_d  = blk_data_q;
        byte_cnt_d  = byte_cnt_q;
        timer_d     = timer_q;
        blk_valid_d = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (sho_edge) begin
                    shreg_d    = {shreg_q[BLK_W-BYTE_W-1:0], data_s2};
                    byte_cnt_d = 5'd1;
                    state_d    = RECV;
                end
            end
            RECV: begin
                // Priority: abort, then a byte, then the timeout.
                if (abort) begin
                    byte_cnt_d = '0;
                    timer_d    = '0;
                    state_d    = IDLE;
                end else if (sho_edge) begin
                    shreg_d = {shreg_q[BLK_W-BYTE_W-1:0], data_s2};
                    timer_d = '0;
                    if (byte_cnt_q == LAST_IDX) begin
                        blk_data_d  = shreg_d;
                        blk_valid_d = 1'b1;
                        byte_cnt_d  = '0;
                        state_d     = IDLE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 5'd1;
                    end
                end else if (timer_q == TMO_LAST) begin
                    frame_err_d = 1'b1;
                    byte_cnt_d  = '0;
                    timer_d     = '0;
                    state_d     = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RECV);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_q        <= 1'b0;
            state_q     <= IDLE;
            shreg_q     <= '0;
            blk_data_q  <= '0;
            byte_cnt_q  <= '0;
            timer_q     <= '0;
            blk_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            s3_q        <= sho_s2;
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            blk_data_q  <= blk_data_d;
            byte_cnt_q  <= byte_cnt_d;
            timer_q     <= timer_d;
            blk_valid_q <= blk_valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign blk_valid = blk_valid_q;
    assign blk_data  = blk_data_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;
    assign byte_cnt  = byte_cnt_q;
endmodule

// File: tb/tb_aes_rx_deframer.sv
// Bench for aes_rx_deframer: drives chip-side byte strobes and compares against a frame-level model.
module tb_aes_rx_deframer;
    import aes_plat_pkg::*;

    localparam int CLK_FREQ      = 50_000_000;
    localparam int CHIP_CLK_FREQ = 1_000_000;
    localparam int RATIO         = CLK_FREQ / CHIP_CLK_FREQ;
    localparam int TMO           = 64 * RATIO;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         abort  = 1'b0;
    logic [8:0]   aes_rx = '0;
    logic         blk_valid;
    logic [127:0] blk_data;
    logic         frame_err;
    logic         busy;
    logic [4:0]   byte_cnt;

    aes_rx_deframer #(
        .CLK_FREQ      (CLK_FREQ),
        .CHIP_CLK_FREQ (CHIP_CLK_FREQ)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .aes_rx    (aes_rx),
        .abort     (abort),
        .blk_valid (blk_valid),
        .blk_data  (blk_data),
        .frame_err (frame_err),
        .busy      (busy),
        .byte_cnt  (byte_cnt)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed events, sampled mid-cycle.
    logic [127:0] v_data[$];
    int           v_cyc[$];
    int           e_cyc[$];
    always @(negedge clk) begin
        if (blk_valid === 1'b1) begin
            v_data.push_back(blk_data);
            v_cyc.push_back(cyc);
        end
        if (frame_err === 1'b1) e_cyc.push_back(cyc);
    end

    // Frame-level model: bytes of the open frame, completed blocks and when they are due.
    logic [7:0]   m_bytes[$];
    logic [127:0] m_blks[$];
    int           m_cyc[$];
    logic [127:0] m_last = '0;
    int           last_rise = 0;
    int           n_chk = 0;
    int           n_fail = 0;

    task automatic mdl_byte(input logic [7:0] b, input int rise);
        logic [127:0] blk;
        m_bytes.push_back(b);
        if (m_bytes.size() == 16) begin
            blk = '0;
            for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = m_bytes[i];
            m_blks.push_back(blk);
            m_cyc.push_back(rise + 3);
            m_last = blk;
            m_bytes.delete();
        end
    endtask

    task automatic clr();
        v_data.delete();
        v_cyc.delete();
        e_cyc.delete();
        m_blks.delete();
        m_cyc.delete();
    endtask

    // Called at a negedge with sho low; returns at a negedge with sho low.
    task automatic send_byte(input logic [7:0] b, input int lo, input int hi);
        aes_rx[7:0] = b;
        repeat (lo) @(negedge clk);
        aes_rx[8] = 1'b1;
        last_rise = cyc;
        mdl_byte(b, cyc);
        repeat (hi) @(negedge clk);
        aes_rx[8] = 1'b0;
    endtask

    function automatic int jit();
        return RATIO + int'($urandom_range(0, 15));
    endfunction

    task automatic test_reset();
        #5;
        n_chk++;
        if ({blk_valid, blk_data, frame_err, busy, byte_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: outputs v=%b d=%h e=%b b=%b c=%0d, expected all zero",
                     blk_valid, blk_data, frame_err, busy, byte_cnt);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_chk++;
        if ({blk_valid, blk_data, frame_err, busy, byte_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_release: outputs v=%b d=%h e=%b b=%b c=%0d, expected all zero",
                     blk_valid, blk_data, frame_err, busy, byte_cnt);
        end
    endtask

    task automatic test_counting();
        int k;
        clr();
        @(negedge clk);
        aes_rx[7:0] = 8'h00;
        repeat (RATIO) @(negedge clk);
        aes_rx[8] = 1'b1;
        k = cyc;
        mdl_byte(8'h00, k);
        repeat (2) @(negedge clk);
        n_chk++;
        if (byte_cnt !== 5'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early: byte_cnt=%0d busy=%b at rise+2, expected 0/0", byte_cnt, busy);
        end
        @(negedge clk);
        n_chk++;
        if (byte_cnt !== 5'd1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL latency_capture: byte_cnt=%0d busy=%b at rise+3, expected 1/1", byte_cnt, busy);
        end
        repeat (RATIO - 3) @(negedge clk);
        aes_rx[8] = 1'b0;
        for (int i = 1; i < 16; i++) begin
            send_byte(8'(i), RATIO, RATIO);
            n_chk++;
            if (byte_cnt !== 5'((i + 1) % 16)) begin
                n_fail++;
                $display("FAIL count_byte_cnt: byte_cnt=%0d after byte %0d, expected %0d",
                         byte_cnt, i, (i + 1) % 16);
            end
        end
        repeat (10) @(negedge clk);
        n_chk++;
        if (v_data.size() != 1 || v_data[0] !== 128'h000102030405060708090A0B0C0D0E0F
            || v_cyc[0] != m_cyc[0]) begin
            n_fail++;
            $display("FAIL count_block: %0d pulses, first=%h@%0d, expected one %h@%0d",
                     v_data.size(), (v_data.size() > 0) ? v_data[0] : 128'h0,
                     (v_cyc.size() > 0) ? v_cyc[0] : -1, m_blks[0], m_cyc[0]);
        end
        n_chk++;
        if (busy !== 1'b0 || e_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL count_idle: busy=%b errs=%0d, expected 0/0", busy, e_cyc.size());
        end
    endtask

    task automatic test_fips();
        logic [127:0] ct;
        ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        clr();
        @(negedge clk);
        for (int i = 0; i < 16; i++) send_byte(ct[127-8*i -: 8], RATIO, RATIO);
        for (int i = 0; i < 16; i++) send_byte(8'hFF, RATIO, RATIO);
        repeat (10) @(negedge clk);
        n_chk++;
        if (v_data.size() != 2) begin
            n_fail++;
            $display("FAIL fips_npulse: %0d blk_valid pulses, expected 2", v_data.size());
        end
        for (int i = 0; i < 2 && i < v_data.size(); i++) begin
            n_chk++;
            if (v_data[i] !== m_blks[i] || v_cyc[i] != m_cyc[i]) begin
                n_fail++;
                $display("FAIL fips_block%0d: %h@%0d, expected %h@%0d",
                         i, v_data[i], v_cyc[i], m_blks[i], m_cyc[i]);
            end
        end
        n_chk++;
        if (v_data.size() > 0 && v_data[0] !== ct) begin
            n_fail++;
            $display("FAIL fips_vector: %h, expected %h", v_data[0], ct);
        end
    endtask

    task automatic test_stall();
        logic [127:0] prev;
        int k;
        clr();
        prev = m_last;
        @(negedge clk);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), jit(), jit());
        k = last_rise;
        repeat (TMO + 20) @(negedge clk);
        m_bytes.delete();
        n_chk++;
        if (e_cyc.size() != 1 || e_cyc[0] != k + 3 + TMO) begin
            n_fail++;
            $display("FAIL stall_err: %0d pulses, first@%0d, expected one @%0d",
                     e_cyc.size(), (e_cyc.size() > 0) ? e_cyc[0] : -1, k + 3 + TMO);
        end
        n_chk++;
        if (busy !== 1'b0 || byte_cnt !== 5'd0 || blk_data !== prev || v_data.size() != 0) begin
            n_fail++;
            $display("FAIL stall_state: busy=%b cnt=%0d data=%h pulses=%0d, expected 0/0/%h/0",
                     busy, byte_cnt, blk_data, v_data.size(), prev);
        end
        for (int i = 0; i < 16; i++) send_byte(8'($urandom), jit(), jit());
        repeat (10) @(negedge clk);
        n_chk++;
        if (v_data.size() != 1 || v_data[0] !== m_blks[0] || v_cyc[0] != m_cyc[0]) begin
            n_fail++;
            $display("FAIL stall_recover: %0d pulses, first=%h, expected one %h",
                     v_data.size(), (v_data.size() > 0) ? v_data[0] : 128'h0, m_blks[0]);
        end
    endtask

    task automatic test_long_strobe();
        clr();
        @(negedge clk);
        send_byte(8'($urandom), RATIO, 10 * RATIO);
        n_chk++;
        if (byte_cnt !== 5'd1) begin
            n_fail++;
            $display("FAIL long_strobe: byte_cnt=%0d after held strobe, expected 1", byte_cnt);
        end
        for (int i = 0; i < 15; i++) begin
            send_byte(8'($urandom), jit(), jit());
            n_chk++;
            if (byte_cnt !== 5'((i + 2) % 16)) begin
                n_fail++;
                $display("FAIL long_count: byte_cnt=%0d, expected %0d", byte_cnt, (i + 2) % 16);
            end
        end
        repeat (10) @(negedge clk);
        n_chk++;
        if (v_data.size() != 1 || v_data[0] !== m_blks[0]) begin
            n_fail++;
            $display("FAIL long_block: %0d pulses, first=%h, expected one %h",
                     v_data.size(), (v_data.size() > 0) ? v_data[0] : 128'h0, m_blks[0]);
        end
    endtask

    task automatic test_reset_mid();
        clr();
        @(negedge clk);
        for (int i = 0; i < 7; i++) send_byte(8'($urandom), jit(), jit());
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({blk_valid, blk_data, frame_err, busy, byte_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: outputs v=%b d=%h e=%b b=%b c=%0d, expected all zero",
                     blk_valid, blk_data, frame_err, busy, byte_cnt);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_bytes.delete();
        m_last = '0;
        for (int i = 0; i < 16; i++) send_byte(8'($urandom), jit(), jit());
        repeat (10) @(negedge clk);
        n_chk++;
        if (v_data.size() != 1 || v_data[0] !== m_blks[0] || v_cyc[0] != m_cyc[0]) begin
            n_fail++;
            $display("FAIL reset_recover: %0d pulses, first=%h, expected one %h",
                     v_data.size(), (v_data.size() > 0) ? v_data[0] : 128'h0, m_blks[0]);
        end
    endtask

    task automatic test_abort();
        clr();
        @(negedge clk);
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), jit(), jit());
        aes_rx[7:0] = 8'($urandom);
        repeat (RATIO) @(negedge clk);
        aes_rx[8] = 1'b1;
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_chk++;
        if (byte_cnt !== 5'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_collide: byte_cnt=%0d busy=%b, expected 0/0", byte_cnt, busy);
        end
        repeat (RATIO - 3) @(negedge clk);
        aes_rx[8] = 1'b0;
        m_bytes.delete();
        repeat (TMO + 20) @(negedge clk);
        n_chk++;
        if (e_cyc.size() != 0 || v_data.size() != 0 || byte_cnt !== 5'd0) begin
            n_fail++;
            $display("FAIL abort_quiet: errs=%0d pulses=%0d cnt=%0d, expected 0/0/0",
                     e_cyc.size(), v_data.size(), byte_cnt);
        end
        for (int i = 0; i < 16; i++) send_byte(8'($urandom), jit(), jit());
        repeat (10) @(negedge clk);
        n_chk++;
        if (v_data.size() != 1 || v_data[0] !== m_blks[0] || v_cyc[0] != m_cyc[0]) begin
            n_fail++;
            $display("FAIL abort_recover: %0d pulses, first=%h, expected one %h",
                     v_data.size(), (v_data.size() > 0) ? v_data[0] : 128'h0, m_blks[0]);
        end
    endtask

    // Second byte's capture lands exactly on the timeout cycle; the byte must win.
    task automatic test_tmo_collision();
        clr();
        @(negedge clk);
        send_byte(8'($urandom), RATIO, RATIO);
        send_byte(8'($urandom), TMO - RATIO, RATIO);
        n_chk++;
        if (byte_cnt !== 5'd2 || e_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL tmo_collide: byte_cnt=%0d errs=%0d, expected 2/0", byte_cnt, e_cyc.size());
        end
        for (int i = 0; i < 14; i++) send_byte(8'($urandom), jit(), jit());
        repeat (10) @(negedge clk);
        n_chk++;
        if (v_data.size() != 1 || v_data[0] !== m_blks[0] || e_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL tmo_block: %0d pulses errs=%0d, first=%h, expected one %h",
                     v_data.size(), e_cyc.size(), (v_data.size() > 0) ? v_data[0] : 128'h0, m_blks[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] prev;
        clr();
        prev = m_last;
        @(negedge clk);
        abort = 1'b1;
        repeat (3) @(negedge clk);
        abort = 1'b0;
        n_chk++;
        if (byte_cnt !== 5'd0 || busy !== 1'b0 || blk_data !== prev || e_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL abort_idle: cnt=%0d busy=%b data=%h errs=%0d, expected 0/0/%h/0",
                     byte_cnt, busy, blk_data, e_cyc.size(), prev);
        end
        for (int i = 0; i < 32; i++) send_byte(8'($urandom), 2, 2);
        repeat (10) @(negedge clk);
        n_chk++;
        if (v_data.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_npulse: %0d blk_valid pulses, expected 2", v_data.size());
        end
        for (int i = 0; i < 2 && i < v_data.size(); i++) begin
            n_chk++;
            if (v_data[i] !== m_blks[i] || v_cyc[i] != m_cyc[i]) begin
                n_fail++;
                $display("FAIL b2b_block%0d: %h@%0d, expected %h@%0d",
                         i, v_data[i], v_cyc[i], m_blks[i], m_cyc[i]);
            end
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_counting();
        test_fips();
        test_stall();
        test_long_strobe();
        test_reset_mid();
        test_abort();
        test_tmo_collision();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
